ysyx_22040383_divider: RTL and testbench
========================================

# ysyx_22040383_divider

Iterative radix-2 restoring divider that executes RV64M divide and remainder operations (div, divu, rem, remu, divw, divuw, remw, remuw) over multiple cycles. It sits beside the execute-stage ALU: EX issues a request over a valid/ready handshake, stalls until the result handshake completes, and takes divide traffic off the single-cycle combinational path. One divide is in flight at a time. Flush support allows the pipeline to kill a divide on a redirect.

## Interface
- Parameters: none. Datapath width is the shared `ysyx_22040383_width` macro, which is 64 bits.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  aborts any in-flight or pending operation
- in_valid  in  1  request valid
- in_ready  out  1  divider can accept; high exactly in IDLE
- a  in  64  dividend
- b  in  64  divisor
- is_signed  in  1  1 = signed (div/rem), 0 = unsigned
- is_word  in  1  1 = 32-bit W-variant
- is_rem  in  1  1 = return remainder, 0 = return quotient
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- result  out  64  registered quotient or remainder
- busy  out  1  state != IDLE

## Operation
- States:
  - IDLE → CALC when in_valid & in_ready, divisor nonzero.
  - IDLE → DONE on accept with divisor == 0.
  - CALC → DONE when the iteration counter reaches N-1.
  - DONE → IDLE when out_valid & out_ready.
- On accept, latch the operands:
  - Word mode uses a[31:0] and b[31:0], sign-extended if is_signed, otherwise zero-extended.
  - Record the quotient sign as sa^sb and the remainder sign as sa.
  - Convert both operands to magnitudes.
- Iteration count N = 32 in word mode, 64 otherwise.
- One restoring step per CALC cycle:
  - Shift {rem, quo} left by one.
  - Trial-subtract the divisor magnitude from the partial remainder, computed one bit wider than the operand.
  - On non-negative, keep the difference and set the quotient LSB.
- Finish, applied when entering DONE:
  - Negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set (signed only).
  - Select the output by is_rem.
  - Word mode sign-extends bit 31 of the result to 64 bits for all four W ops, including divuw and remuw.
- Divide by zero: quotient = all ones (64'hFFFF_FFFF_FFFF_FFFF, or 32'hFFFFFFFF sign-extended); remainder = dividend (word: sign-extended a[31:0]).
- Signed overflow (most-negative ÷ -1): quotient = dividend, remainder = 0. The magnitude datapath produces this naturally; the bench checks it explicitly.
- Flush has highest priority in every state:
  - Next state IDLE, out_valid cleared.
  - An in_valid accepted in the same cycle as flush is dropped.
- No new request is accepted while out_valid is held; back-pressure via out_ready may hold DONE indefinitely.

## Timing
- Reset values:
  - state IDLE, in_ready 1, busy 0.
  - out_valid 0, result 64'h0, counter 0, internal registers 0.
- Accept at cycle T; CALC occupies T+1 … T+N; out_valid rises at T+N+1.
  - Latency is 65 cycles (64-bit) or 33 cycles (word).
- Divide by zero: out_valid at T+1.
- result is stable while out_valid = 1 and out_ready = 0.
- in_ready returns high the cycle after the output handshake. Minimum issue interval is N+2 cycles.
- rst asserted mid-operation clears immediately (asynchronous); no result is produced.

## Structure
- Add to para.v:
  - state encodings `ysyx_22040383_div_idle/_calc/_done` (2 bits)
  - `ysyx_22040383_div_cnt_w` = 7
- Reuse `ysyx_22040383_width`.
- One natural sub-module: ysyx_22040383_div_step, a combinational single restoring iteration with inputs partial remainder, quotient and divisor, and outputs the next remainder and quotient.
- FSM, counter, sign fix-up and handshake live in the top module.

## Test plan
- divu a=100, b=7 → out_valid 65 cycles after accept, result = 14; same with is_rem → 2.
- div a=-7 (64'hFFFF_FFFF_FFFF_FFF9), b=2 → quotient 64'hFFFF_FFFF_FFFF_FFFD (-3); rem → 64'hFFFF_FFFF_FFFF_FFFF (-1).
- divw a=64'h0000_0000_8000_0000, b=64'hFFFF_FFFF_FFFF_FFFF → 64'hFFFF_FFFF_8000_0000 after 33 cycles; remw → 0.
- div by zero: divu a=5, b=0 → 64'hFFFF_FFFF_FFFF_FFFF at T+1; remu → 5.
- Back-pressure then flush:
  - Hold out_ready=0 for 10 cycles → result stable, in_ready 0.
  - Pulse flush during CALC cycle 20 of a new op → next cycle IDLE, out_valid never rises.
- Async rst in CALC → outputs take reset values without waiting for a clock edge; the next request completes correctly.

Source files
------------

// File: rtl/ysyx_22040383_divider_pkg.sv
// rtl/ysyx_22040383_divider_pkg.sv - shared widths, FSM encoding and helpers for the divider
package ysyx_22040383_divider_pkg;

    localparam int WIDTH = 64;
    localparam int CNT_W = 7;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // W-variant results are always the low word sign-extended to the full width
    function automatic logic [WIDTH-1:0] sext_word(input logic [31:0] v);
        return {{(WIDTH-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22040383_div_step.sv
// rtl/ysyx_22040383_div_step.sv - one combinational restoring-division iteration
module ysyx_22040383_div_step
    import ysyx_22040383_divider_pkg::*;
(
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Shift {rem, quo} left and trial-subtract one bit wider so the sign bit is the borrow
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_i};
        if (!diff[WIDTH]) begin
            rem_o = diff[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ysyx_22040383_divider.sv
// rtl/ysyx_22040383_divider.sv - iterative radix-2 restoring divider for RV64M div/rem ops
module ysyx_22040383_divider
    import ysyx_22040383_divider_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             is_word,
    input  logic             is_rem,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             word_q;
    logic             is_rem_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;

    logic [WIDTH-1:0] a_ext;
    logic [WIDTH-1:0] b_ext;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quo_init;
    logic             b_zero;
    logic [WIDTH-1:0] dz_sel;
    logic [WIDTH-1:0] dz_result;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [CNT_W-1:0] last_cnt;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] fin_sel;
    logic [WIDTH-1:0] fin_result;

    // Operand preparation at accept: width extension, sign capture and magnitudes
    always_comb begin
        if (is_word) begin
            a_ext = is_signed ? sext_word(a[31:0]) : {{(WIDTH-32){1'b0}}, a[31:0]};
            b_ext = is_signed ? sext_word(b[31:0]) : {{(WIDTH-32){1'b0}}, b[31:0]};
        end else begin
            a_ext = a;
            b_ext = b;
        end
        sa     = is_signed & a_ext[WIDTH-1];
        sb     = is_signed & b_ext[WIDTH-1];
        a_mag  = sa ? -a_ext : a_ext;
        b_mag  = sb ? -b_ext : b_ext;
        b_zero = (b_ext == '0);
        // Word dividends sit in the upper half so the shift feeds their bits into rem first
        quo_init  = is_word ? {a_mag[31:0], 32'h0} : a_mag;
        dz_sel    = is_rem ? a_ext : '1;
        dz_result = is_word ? sext_word(dz_sel[31:0]) : dz_sel;
    end

    ysyx_22040383_div_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Sign fix-up and result selection applied to the final iteration's output
    always_comb begin
        last_cnt   = word_q ? CNT_W'(31) : CNT_W'(63);
        q_fix      = q_neg_q ? -step_quo : step_quo;
        r_fix      = r_neg_q ? -step_rem : step_rem;
        fin_sel    = is_rem_q ? r_fix : q_fix;
        fin_result = word_q ? sext_word(fin_sel[31:0]) : fin_sel;
    end

    // Divider FSM: accept, iterate, hold result until consumed; flush overrides everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DIV_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            word_q      <= 1'b0;
            is_rem_q    <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (flush) begin
            state_q     <= DIV_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (in_valid) begin
                        word_q   <= is_word;
                        is_rem_q <= is_rem;
                        q_neg_q  <= sa ^ sb;
                        r_neg_q  <= sa;
                        rem_q    <= '0;
                        quo_q    <= quo_init;
                        dvs_q    <= b_mag;
                        cnt_q    <= '0;
                        if (b_zero) begin
                            result_q    <= dz_result;
                            out_valid_q <= 1'b1;
                            state_q     <= DIV_DONE;
                        end else begin
                            state_q <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == last_cnt) begin
                        result_q    <= fin_result;
                        out_valid_q <= 1'b1;
                        state_q     <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= DIV_IDLE;
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == DIV_IDLE);
    assign busy      = (state_q != DIV_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_ysyx_22040383_divider.sv
// tb/tb_ysyx_22040383_divider.sv - directed table-driven bench for the divider
module tb_ysyx_22040383_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        is_signed;
    logic        is_word;
    logic        is_rem;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] va;
        logic [63:0] vb;
        logic        s;
        logic        w;
        logic        r;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    ysyx_22040383_divider dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .is_word   (is_word),
        .is_rem    (is_rem),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [63:0] ia, input logic [63:0] ib,
                         input logic s, input logic w, input logic r);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        a = ia; b = ib; is_signed = s; is_word = w; is_rem = r;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // lat counts cycles from the accept edge: 1 means out_valid in the cycle after accept
    task automatic wait_out(output logic [63:0] got, output int lat);
        lat = 1;
        while (!out_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = result;
    endtask

    initial begin
        logic [63:0] got;
        int          lat;
        logic        seen;

        vecs[0]  = '{64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, 65};
        vecs[1]  = '{64'd100, 64'd7, 1'b0, 1'b0, 1'b1, 64'd2, 65};
        vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65};
        vecs[3]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        vecs[4]  = '{64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000, 33};
        vecs[5]  = '{64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 64'h0, 33};
        vecs[6]  = '{64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[7]  = '{64'd5, 64'd0, 1'b0, 1'b0, 1'b1, 64'd5, 1};
        vecs[8]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 65};
        vecs[9]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 64'h0, 65};
        vecs[10] = '{64'h1234_5678_FFFF_FFFE, 64'h0000_0000_0000_0001, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 33};
        vecs[11] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 33};
        vecs[12] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        vecs[13] = '{64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0001, 1};
        vecs[14] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65};
        vecs[15] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1, 64'd1, 65};
        vecs[16] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 65};
        vecs[17] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 65};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; is_signed = 1'b0; is_word = 1'b0; is_rem = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", {63'h0, in_ready}, 64'd1);
        chk("reset_busy", {63'h0, busy}, 64'd0);
        chk("reset_out_valid", {63'h0, out_valid}, 64'd0);
        chk("reset_result", result, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].va, vecs[i].vb, vecs[i].s, vecs[i].w, vecs[i].r);
            wait_out(got, lat);
            chk($sformatf("v%0d_result", i), got, vecs[i].exp);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_in_ready_after", i), {63'h0, in_ready}, 64'd1);
        end

        // Back-pressure: result and in_ready must hold while out_ready is low
        out_ready = 1'b0;
        issue(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
        wait_out(got, lat);
        chk("bp_result", got, 64'd14);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold_result_%0d", k), result, 64'd14);
            chk($sformatf("bp_hold_in_ready_%0d", k), {63'h0, in_ready}, 64'd0);
            chk($sformatf("bp_hold_valid_%0d", k), {63'h0, out_valid}, 64'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", {63'h0, out_valid}, 64'd0);
        chk("bp_release_in_ready", {63'h0, in_ready}, 64'd1);

        // Flush during the 20th CALC cycle kills the operation
        issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b0);
        repeat (19) @(posedge clk);
        @(negedge clk);
        chk("flush_pre_busy", {63'h0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy", {63'h0, busy}, 64'd0);
        chk("flush_in_ready", {63'h0, in_ready}, 64'd1);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_valid", {63'h0, seen}, 64'd0);

        // A request presented together with flush is dropped (divide-by-zero would finish at once)
        @(negedge clk);
        a = 64'd9; b = 64'd0; is_signed = 1'b0; is_word = 1'b0; is_rem = 1'b0;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept_busy", {63'h0, busy}, 64'd0);
        chk("flush_accept_valid", {63'h0, out_valid}, 64'd0);

        // Asynchronous reset mid-CALC takes effect before the next clock edge
        issue(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {63'h0, busy}, 64'd0);
        chk("arst_in_ready", {63'h0, in_ready}, 64'd1);
        chk("arst_out_valid", {63'h0, out_valid}, 64'd0);
        chk("arst_result", result, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        issue(64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0);
        wait_out(got, lat);
        chk("post_rst_result", got, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("post_rst_latency", 64'(lat), 64'd65);
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
